// File: rtl/wallace_multiplier.sv
// Unsigned 32x32 -> 64-bit multiplier.
// Partial products are reduced by a Wallace tree of 3:2 carry-save
// compressors, 32 -> 22 -> 15 -> 10 -> 7 -> 5 -> 4 -> 3 -> 2 rows, then
// summed by one carry-propagate adder. The product is registered, so the
// latency is one cycle.
module wallace_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] s
);

  // Row count of each layer, and where that layer's rows start in node[].
  localparam int NL = 8;
  localparam int ROWS [0:NL] = '{32, 22, 15, 10, 7, 5, 4, 3, 2};
  localparam int OFF  [0:NL] = '{ 0, 32, 54, 69, 79, 86, 91, 95, 98};
  localparam int NODES = 100;

  // Every row of every layer, flattened into one array.
  logic [63:0] node [NODES];
  logic [63:0] s_d;
  logic [63:0] s_q;

  // Full-adder sum, one full adder per column.
  function automatic logic [63:0] fa_sum(input logic [63:0] x,
                                         input logic [63:0] y,
                                         input logic [63:0] z);
    return x ^ y ^ z;
  endfunction

  // Full-adder carry, moved up one column. The carry out of column 63 is
  // dropped: it is always zero for a 32x32 product.
  function automatic logic [63:0] fa_carry(input logic [63:0] x,
                                           input logic [63:0] y,
                                           input logic [63:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  genvar l, g, r;

  // Layer 0: partial product row r is a gated by b[r], shifted left by r.
  for (r = 0; r < 32; r++) begin : g_pp
    assign node[r] = {32'h0, a & {32{b[r]}}} << r;
  end

  // Layers 1..8: compress groups of three rows into a sum row and a carry
  // row. Rows left over after the last full group pass through unchanged.
  for (l = 1; l <= NL; l++) begin : g_lyr
    localparam int NP  = ROWS[l-1];
    localparam int NG  = NP / 3;
    localparam int SRC = OFF[l-1];
    localparam int DST = OFF[l];
    for (g = 0; g < NG; g++) begin : g_csa
      assign node[DST + 2*g]     = fa_sum  (node[SRC + 3*g], node[SRC + 3*g + 1],
                                            node[SRC + 3*g + 2]);
      assign node[DST + 2*g + 1] = fa_carry(node[SRC + 3*g], node[SRC + 3*g + 1],
                                            node[SRC + 3*g + 2]);
    end
    for (r = 3*NG; r < NP; r++) begin : g_pass
      assign node[DST + 2*NG + (r - 3*NG)] = node[SRC + r];
    end
  end

  // Final carry-propagate add of the two remaining rows.
  always_comb begin
    s_d = node[OFF[NL]] + node[OFF[NL] + 1];
  end

  // Product register; cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= 64'h0;
    else        s_q <= s_d;
  end

  assign s = s_q;

endmodule

// File: tb/tb_wallace_multiplier.sv
// Directed and random test of wallace_multiplier against a 64-bit
// arithmetic reference.
module tb_wallace_multiplier;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] s;

  int errors = 0;
  int checks = 0;

  wallace_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .s     (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return 64'(x) * 64'(y);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one pair on a falling edge and check it one rising edge later.
  task automatic apply_check(input string tag, input logic [31:0] x,
                             input logic [31:0] y, input logic [63:0] exp);
    @(negedge clk);
    a = x;
    b = y;
    @(negedge clk);
    check(tag, s, exp);
  endtask

  logic [31:0] ra, rb;
  logic [63:0] exp_prev;
  logic [63:0] held;

  initial begin
    // Reset held with maximal operands: output must stay zero.
    rst_n = 1'b0;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    #2;
    check("reset_async_initial", s, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", s, 64'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", s, 64'hFFFF_FFFE_0000_0001);

    // Max then zero.
    apply_check("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    apply_check("zero", 32'h0, 32'h0, 64'h0);
    apply_check("zero_a", 32'h0, 32'hDEAD_BEEF, 64'h0);
    apply_check("zero_b", 32'h1234_5678, 32'h0, 64'h0);

    // Mixed bits and edge operands.
    apply_check("mixed", 32'h0000_9129, 32'h0000_9111, 64'h0000_0000_5241_DCB9);
    apply_check("max_x1", 32'hFFFF_FFFF, 32'h1, 64'h0000_0000_FFFF_FFFF);
    apply_check("msb_x_msb", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    apply_check("one_x_msb", 32'h1, 32'h8000_0000, 64'h0000_0000_8000_0000);

    // Stable operands hold the output constant.
    @(negedge clk);
    a = 32'hCAFE_F00D;
    b = 32'h0BAD_BEEF;
    @(negedge clk);
    held = s;
    check("stable_first", held, ref_mul(32'hCAFE_F00D, 32'h0BAD_BEEF));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stable_hold", s, ref_mul(32'hCAFE_F00D, 32'h0BAD_BEEF));
    end

    // Back-to-back directed pairs, one new pair per cycle.
    @(negedge clk);
    a = 32'h0000_0003; b = 32'h0000_0005; exp_prev = ref_mul(a, b);
    @(negedge clk);
    check("b2b_0", s, exp_prev);
    a = 32'h7FFF_FFFF; b = 32'h0000_0002; exp_prev = ref_mul(a, b);
    @(negedge clk);
    check("b2b_1", s, exp_prev);
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; exp_prev = ref_mul(a, b);
    @(negedge clk);
    check("b2b_2", s, exp_prev);
    a = 32'hFFFF_0000; b = 32'h0001_FFFF; exp_prev = ref_mul(a, b);
    @(negedge clk);
    check("b2b_3", s, exp_prev);

    // Asynchronous reset in the middle of a cycle.
    a = 32'h1357_9BDF; b = 32'h2468_ACE0;
    @(posedge clk);
    #2;
    check("pre_async_rst", s, ref_mul(32'h1357_9BDF, 32'h2468_ACE0));
    rst_n = 1'b0;
    #1;
    check("async_rst_clear", s, 64'h0);
    @(negedge clk);
    check("async_rst_hold", s, 64'h0);
    a = 32'h0000_0011; b = 32'h0000_0013;
    rst_n = 1'b1;
    @(negedge clk);
    check("async_rst_release", s, 64'd323);

    // Random back-to-back pairs; each product checked the cycle after.
    ra = $urandom;
    rb = $urandom;
    a = ra; b = rb;
    exp_prev = ref_mul(ra, rb);
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      check("random", s, exp_prev);
      case (i % 8)
        0:       begin ra = $urandom; rb = 32'hFFFF_FFFF; end
        1:       begin ra = 32'(1) << $urandom_range(31, 0); rb = $urandom; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      a = ra; b = rb;
      exp_prev = ref_mul(ra, rb);
    end
    @(negedge clk);
    check("random_last", s, exp_prev);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
